ifetch_unit: RTL and testbench

Instruction-fetch stage for the multicycle processor. It sits directly downstream of the program counter: it takes the current PC value, runs a request/acknowledge read on the instruction memory port, latches the returned word into the instruction register, and computes PC+4. It then pulses a write-enable back to the PC. It also detects misaligned fetch addresses and, optionally, memory-response timeouts.

---
 rtl/ifetch_unit.sv | 159 +++++++++++++++
 tb/tb_ifetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: one req/ack memory read per fetch_go, result in ir/npc, PC write pulse.
// Optional response watchdog compiled in with IFETCH_TIMEOUT_EN (uses TIMEOUT).
module ifetch_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_addr,
    input  logic        fetch_go,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] npc,
    output logic        fetch_done,
    output logic        pc_wr,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_MISALIGN  = 2'b01;
    localparam logic [1:0] FC_TIMEOUT   = 2'b10;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] addr_reg;
    logic [31:0] ir_reg;
    logic [31:0] npc_reg;
    logic [1:0]  fault_code_reg;

    logic go_ok;
    logic go_bad;
    logic ack_take;
    logic req_wait;
    logic timeout_hit;

    // flush masks every other event so nothing it races against can take effect
    assign go_ok    = (state_reg == S_IDLE) && fetch_go && !flush && (pc_addr[1:0] == 2'b00);
    assign go_bad   = (state_reg == S_IDLE) && fetch_go && !flush && (pc_addr[1:0] != 2'b00);
    assign ack_take = (state_reg == S_REQ) && mem_ack && !flush;
    assign req_wait = (state_reg == S_REQ) && !mem_ack && !flush;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= 8'd0;
        end else if (go_ok) begin
            wait_cnt_reg <= 8'd0;
        end else if (req_wait) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // an ack in the final allowed cycle completes normally
    assign timeout_hit = req_wait && (wait_cnt_reg == TIMEOUT_LAST);
`else
    // TIMEOUT only matters when the watchdog is compiled in
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0) && req_wait;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (go_ok) begin
                        state_next = S_REQ;
                    end else if (go_bad) begin
                        state_next = S_FAULT;
                    end
                end
                S_REQ: begin
                    if (ack_take) begin
                        state_next = S_DONE;
                    end else if (timeout_hit) begin
                        state_next = S_FAULT;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                S_FAULT: state_next = S_FAULT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        fetch_done = 1'b0;
        pc_wr      = 1'b0;
        fault      = 1'b0;
        busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_REQ:   mem_req = 1'b1;
            S_DONE: begin
                fetch_done = 1'b1;
                pc_wr      = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= 32'd0;
            ir_reg         <= 32'd0;
            npc_reg        <= 32'd0;
            fault_code_reg <= FC_NONE;
        end else begin
            if (go_ok) begin
                addr_reg <= pc_addr;
            end
            if (ack_take) begin
                ir_reg  <= mem_rdata;
                npc_reg <= addr_reg + 32'd4;
            end
            if (flush) begin
                fault_code_reg <= FC_NONE;
            end else if (go_bad) begin
                fault_code_reg <= FC_MISALIGN;
            end else if (timeout_hit) begin
                fault_code_reg <= FC_TIMEOUT;
            end
        end
    end

    assign mem_addr   = addr_reg;
    assign ir         = ir_reg;
    assign npc        = npc_reg;
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized fetch transactions checked against a transaction-level expectation of ifetch_unit.
module tb_ifetch_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        fetch_go;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        fetch_done;
    logic        pc_wr;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int checks   = 0;
    int failures = 0;

    // expected architectural registers
    logic [31:0] ir_exp;
    logic [31:0] npc_exp;

    ifetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_addr    (pc_addr),
        .fetch_go   (fetch_go),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .npc        (npc),
        .fetch_done (fetch_done),
        .pc_wr      (pc_wr),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_go  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        pc_addr   = $urandom;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},       busy,       32'd0);
        check({tag, ".mem_req"},    mem_req,    32'd0);
        check({tag, ".fetch_done"}, fetch_done, 32'd0);
        check({tag, ".pc_wr"},      pc_wr,      32'd0);
        check({tag, ".fault"},      fault,      32'd0);
        check({tag, ".fault_code"}, fault_code, 32'd0);
        check({tag, ".ir"},         ir,         ir_exp);
        check({tag, ".npc"},        npc,        npc_exp);
    endtask

    // Aligned fetch with 'waits' unacked REQ cycles; noisy adds ignored fetch_go/mem_ack pulses.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                            input int waits, input bit noisy);
        pc_addr  = addr;
        fetch_go = 1'b1;
        mem_ack  = 1'b0;
        step();
        for (int c = 0; c <= waits; c++) begin
            check("fetch.mem_req",    mem_req,    32'd1);
            check("fetch.mem_addr",   mem_addr,   addr);
            check("fetch.busy",       busy,       32'd1);
            check("fetch.early_done", fetch_done, 32'd0);
            fetch_go  = noisy && ($urandom_range(0, 1) == 1);
            pc_addr   = $urandom & 32'hFFFF_FFFC;
            mem_ack   = (c == waits);
            mem_rdata = (c == waits) ? rdata : $urandom;
            step();
        end
        ir_exp  = rdata;
        npc_exp = addr + 32'd4;
        check("done.fetch_done", fetch_done, 32'd1);
        check("done.pc_wr",      pc_wr,      32'd1);
        check("done.ir",         ir,         ir_exp);
        check("done.npc",        npc,        npc_exp);
        check("done.mem_req",    mem_req,    32'd0);
        fetch_go  = noisy;
        mem_ack   = noisy;
        mem_rdata = $urandom;
        pc_addr   = $urandom & 32'hFFFF_FFFC;
        step();
        idle_inputs();
        check_idle("after_done");
        $display("fetch addr=%h rdata=%h waits=%0d noisy=%0d ir=%h npc=%h",
                 addr, rdata, waits, noisy, ir, npc);
    endtask

    task automatic do_misaligned(input logic [31:0] addr);
        int hold;
        pc_addr  = addr;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        check("mis.fault",      fault,      32'd1);
        check("mis.fault_code", fault_code, 32'd1);
        check("mis.mem_req",    mem_req,    32'd0);
        check("mis.pc_wr",      pc_wr,      32'd0);
        check("mis.busy",       busy,       32'd1);
        hold = $urandom_range(1, 4);
        for (int i = 0; i < hold; i++) begin
            fetch_go  = ($urandom_range(0, 1) == 1);
            pc_addr   = $urandom & 32'hFFFF_FFFC;
            mem_ack   = ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            step();
            check("mis_hold.fault",   fault,   32'd1);
            check("mis_hold.mem_req", mem_req, 32'd0);
            check("mis_hold.pc_wr",   pc_wr,   32'd0);
            check("mis_hold.ir",      ir,      ir_exp);
        end
        flush    = 1'b1;
        fetch_go = 1'b1;
        mem_ack  = 1'b0;
        step();
        idle_inputs();
        check_idle("mis_flush");
        $display("misaligned addr=%h hold=%0d flushed", addr, hold);
    endtask

    task automatic do_flush_req(input logic [31:0] addr, input int waits);
        pc_addr  = addr;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        for (int c = 0; c < waits; c++) begin
            check("fl.mem_req", mem_req, 32'd1);
            step();
        end
        check("fl.mem_req_pre", mem_req, 32'd1);
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        step();
        idle_inputs();
        check_idle("fl_after");
        step();
        check("fl.late_done", fetch_done, 32'd0);
        check("fl.late_ir",   ir,         ir_exp);
        $display("flush_req addr=%h waits=%0d", addr, waits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] a;
        int kind;
        rst_n   = 1'b0;
        ir_exp  = 32'd0;
        npc_exp = 32'd0;
        idle_inputs();
        step();
        step();
        check_idle("reset");
        check("reset.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_fetch(32'h0000_3000, 32'h2008_0005, 0, 1'b0);
        do_fetch(32'h0000_3000, 32'h1234_5678, 3, 1'b1);
        do_misaligned(32'h0000_3002);
        do_fetch(32'hFFFF_FFFC, 32'hCAFE_F00D, 1, 1'b0);
        check("wrap.npc", npc, 32'h0000_0000);
        do_flush_req(32'h0000_4000, 0);
        do_flush_req(32'h0000_4100, 2);

        // flush beats a simultaneous aligned fetch_go in IDLE
        flush    = 1'b1;
        fetch_go = 1'b1;
        pc_addr  = 32'h0000_5000;
        step();
        idle_inputs();
        check_idle("flush_idle");

        // asynchronous reset in the middle of REQ
        pc_addr  = 32'h0000_6000;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        step();
        check("rst_mid.mem_req_pre", mem_req, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        ir_exp  = 32'd0;
        npc_exp = 32'd0;
        check_idle("rst_mid");
        check("rst_mid.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_idle("rst_release");

`ifdef IFETCH_TIMEOUT_EN
        pc_addr  = 32'h0000_0100;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        for (int i = 1; i <= int'(TIMEOUT); i++) begin
            check("to.mem_req", mem_req, 32'd1);
            step();
        end
        check("to.fault",      fault,      32'd1);
        check("to.fault_code", fault_code, 32'd2);
        check("to.mem_req_off", mem_req,   32'd0);
        check("to.pc_wr",      pc_wr,      32'd0);
        flush = 1'b1;
        step();
        idle_inputs();
        check_idle("to_flush");
        $display("timeout no-ack TIMEOUT=%0d fault raised", TIMEOUT);

        pc_addr  = 32'h0000_0200;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            check("to_last.mem_req", mem_req, 32'd1);
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_0F0F;
        step();
        mem_ack = 1'b0;
        ir_exp  = 32'hA5A5_0F0F;
        npc_exp = 32'h0000_0204;
        check("to_last.fetch_done", fetch_done, 32'd1);
        check("to_last.fault",      fault,      32'd0);
        check("to_last.ir",         ir,         ir_exp);
        step();
        check_idle("to_last_after");
        $display("timeout ack on last allowed cycle completed");
`else
        pc_addr  = 32'h0000_0300;
        fetch_go = 1'b1;
        step();
        fetch_go = 1'b0;
        repeat (100) step();
        check("nowd.busy",       busy,       32'd1);
        check("nowd.fault",      fault,      32'd0);
        check("nowd.mem_req",    mem_req,    32'd1);
        check("nowd.fault_code", fault_code, 32'd0);
        flush = 1'b1;
        step();
        idle_inputs();
        check_idle("nowd_flush");
        $display("no watchdog: 100 cycles without ack still waiting");
`endif

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                do_fetch($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 6),
                         ($urandom_range(0, 1) == 1));
            end else if (kind == 7) begin
                a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                do_misaligned(a);
            end else if (kind == 8) begin
                do_flush_req($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4));
            end else begin
                a = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
                do_fetch(a, $urandom, $urandom_range(0, 3), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
